stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear sequencer for the stopwatch datapath. It turns two synchronized push-button levels into the time-counter controls:
- `cnt_en`, the tick enable.
- `cnt_clr`, the counter clear.
- `lap_capture` and `disp_freeze`, the display/lap-register controls.

It also owns the prescaler that sets the count rate. It sits between the button synchronizers and the BCD time counter / display mux.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_ctrl_edge_det.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 123 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and helpers for the stopwatch run/pause/lap sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } sw_state_t;

    // True in the states where the time counter is allowed to advance.
    function automatic logic is_running(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_det.sv
// Rising-edge detector for an already-synchronized button level.
// The history flop resets to 1 so a button held through reset is ignored
// until it has been released and pressed again.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level; reset value 1 masks buttons held through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: turns start/stop and lap/reset button edges into
// time-counter and display controls, and owns the tick prescaler.
//
//   state | meaning
//   IDLE  | cleared, counter stopped, prescaler held at 0
//   RUN   | counting, display live
//   PAUSE | counting stopped, prescaler phase held for resume
//   LAP   | counting, display frozen on the captured lap time
//
// TICK_DIV must be at least 2.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_ss,
    input  logic btn_lap,
    output logic cnt_en,
    output logic cnt_clr,
    output logic lap_capture,
    output logic disp_freeze,
    output logic run
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          w_ss_rise;
    logic          w_lap_rise;
    logic          w_ss_evt;
    logic          w_lap_evt;
    sw_state_t     w_state_nxt;

    sw_state_t     r_state;
    logic [PW-1:0] r_presc;
    logic          r_cnt_en;
    logic          r_cnt_clr;
    logic          r_lap_capture;
    logic          r_disp_freeze;
    logic          r_run;

    edge_det u_ss_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (btn_ss),
        .o_rise  (w_ss_rise)
    );

    edge_det u_lap_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (btn_lap),
        .o_rise  (w_lap_rise)
    );

    // Both buttons rising together is ambiguous, so neither is acted on.
    assign w_ss_evt  = w_ss_rise & ~w_lap_rise;
    assign w_lap_evt = w_lap_rise & ~w_ss_rise;

    // Next-state decode from the qualified button events.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_ss_evt) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_ss_evt)       w_state_nxt = PAUSE;
                else if (w_lap_evt) w_state_nxt = LAP;
            end
            LAP: begin
                if (w_ss_evt)       w_state_nxt = PAUSE;
                else if (w_lap_evt) w_state_nxt = RUN;
            end
            PAUSE: begin
                if (w_ss_evt)       w_state_nxt = RUN;
                else if (w_lap_evt) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with all outputs registered from the transition being taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_run         <= 1'b0;
            r_disp_freeze <= 1'b0;
            r_lap_capture <= 1'b0;
            r_cnt_clr     <= 1'b0;
            r_cnt_en      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_run         <= is_running(w_state_nxt);
            r_disp_freeze <= (w_state_nxt == LAP);
            r_lap_capture <= (r_state == RUN) && w_lap_evt;
            r_cnt_clr     <= (r_state == PAUSE) && w_lap_evt;
            // No tick on the cycle the sequencer leaves RUN/LAP.
            r_cnt_en      <= is_running(r_state) && is_running(w_state_nxt)
                             && (r_presc == PRESC_LAST);
        end
    end

    // Prescaler: free-runs while counting, holds its phase in PAUSE, zero in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
            r_presc <= '0;
        end else if (is_running(r_state)) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    assign cnt_en      = r_cnt_en;
    assign cnt_clr     = r_cnt_clr;
    assign lap_capture = r_lap_capture;
    assign disp_freeze = r_disp_freeze;
    assign run         = r_run;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV = 4. Output vector order in all
// expectations is {run, disp_freeze, cnt_en, cnt_clr, lap_capture}.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_ss = 1'b0;
    logic btn_lap = 1'b0;
    logic cnt_en;
    logic cnt_clr;
    logic lap_capture;
    logic disp_freeze;
    logic run;
    logic [4:0] outs;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_ss      (btn_ss),
        .btn_lap     (btn_lap),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .lap_capture (lap_capture),
        .disp_freeze (disp_freeze),
        .run         (run)
    );

    assign outs = {run, disp_freeze, cnt_en, cnt_clr, lap_capture};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       ss;
        logic       lap;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        int         due;
        logic [4:0] exp;
        string      name;
    } sb_t;

    vec_t vecs[$];
    sb_t  q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_ticks = 0;
    logic count_ticks = 1'b0;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b (run,frz,en,clr,cap)", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare every scoreboard entry that has come due in the current cycle.
    task automatic retire();
        sb_t e;
        if (count_ticks && cnt_en) n_ticks++;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due != cyc) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s: entry for cyc %0d checked late at cyc %0d", e.name, e.due, cyc);
            end else begin
                chk(e.name, outs, e.exp);
            end
        end
    endtask

    // Drive one cycle of button levels; exp is the output vector of the next cycle.
    task automatic drive(input logic ss, input logic lap, input logic [4:0] exp, input string name);
        @(posedge clk);
        #1;
        btn_ss  = ss;
        btn_lap = lap;
        q.push_back('{cyc + 1, exp, name});
        @(negedge clk);
        retire();
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        @(negedge clk);
        retire();
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations never checked", q.size());
            q.delete();
        end
    endtask

    task automatic apply_reset(input logic ss_hold);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        btn_ss  = ss_hold;
        btn_lap = 1'b0;
        @(negedge clk);
        chk("reset_state", outs, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // ss, lap, expected outputs in the following cycle
        vecs.push_back('{1'b0, 1'b0, 5'b00000});  // settle edge detectors
        vecs.push_back('{1'b1, 1'b0, 5'b10000});  // IDLE -> RUN
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10100});  // first tick
        vecs.push_back('{1'b0, 1'b1, 5'b11001});  // RUN -> LAP, capture
        vecs.push_back('{1'b0, 1'b0, 5'b11000});
        vecs.push_back('{1'b0, 1'b0, 5'b11000});
        vecs.push_back('{1'b0, 1'b0, 5'b11100});  // tick continues in LAP
        vecs.push_back('{1'b0, 1'b1, 5'b10000});  // LAP -> RUN, no capture
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b1, 1'b0, 5'b00000});  // pause on terminal count: no tick
        vecs.push_back('{1'b0, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 1'b0, 5'b00000});
        vecs.push_back('{1'b1, 1'b0, 5'b10000});  // PAUSE -> RUN
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10100});
        vecs.push_back('{1'b1, 1'b0, 5'b00000});  // RUN -> PAUSE
        vecs.push_back('{1'b0, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 1'b1, 5'b00010});  // PAUSE -> IDLE, clear
        vecs.push_back('{1'b0, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 1'b1, 5'b00000});  // lap in IDLE ignored
        vecs.push_back('{1'b0, 1'b0, 5'b00000});
        vecs.push_back('{1'b1, 1'b0, 5'b10000});  // IDLE -> RUN, presc from 0
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10100});
        vecs.push_back('{1'b1, 1'b1, 5'b10000});  // simultaneous rises ignored
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5'b10100});

        apply_reset(1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ss, vecs[i].lap, vecs[i].exp, $sformatf("table[%0d]", i));
        end

        // ss held for 50 cycles: one RUN -> PAUSE transition only
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 1'b0, 5'b00000, "ss_held");
        end
        drive(1'b0, 1'b0, 5'b00000, "ss_released");
        drain();

        // Tick cadence over 40 cycles, then pause with the prescaler at 2
        apply_reset(1'b0);
        drive(1'b0, 1'b0, 5'b00000, "b_settle");
        drive(1'b1, 1'b0, 5'b10000, "b_start");
        n_ticks     = 0;
        count_ticks = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            drive(1'b0, 1'b0, (k % 4 == 0) ? 5'b10100 : 5'b10000, "b_cadence");
        end
        drive(1'b0, 1'b0, 5'b10000, "b_pre_pause");
        count_ticks = 1'b0;
        chk_int("b_tick_count", n_ticks, 10);
        drive(1'b1, 1'b0, 5'b00000, "b_pause");
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 5'b00000, "b_paused");
        end
        drive(1'b1, 1'b0, 5'b10000, "b_resume");
        drive(1'b0, 1'b0, 5'b10000, "b_resume_wait");
        drive(1'b0, 1'b0, 5'b10100, "b_resume_tick");
        drive(1'b0, 1'b0, 5'b10000, "b_after_tick");
        drain();

        // Start/stop held through reset release is ignored until re-pressed
        apply_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 5'b00000, "d_held_thru_rst");
        end
        drive(1'b0, 1'b0, 5'b00000, "d_release");
        drive(1'b1, 1'b0, 5'b10000, "d_press");
        drive(1'b0, 1'b0, 5'b10000, "d_running");
        drain();

        // Asynchronous reset while in LAP between ticks
        apply_reset(1'b0);
        drive(1'b0, 1'b0, 5'b00000, "e_settle");
        drive(1'b1, 1'b0, 5'b10000, "e_start");
        drive(1'b0, 1'b0, 5'b10000, "e_run");
        drive(1'b0, 1'b1, 5'b11001, "e_lap");
        drive(1'b0, 1'b0, 5'b11000, "e_frozen");
        drain();
        #2;
        rst = 1'b1;
        #1;
        chk("e_async_rst", outs, 5'b00000);
        @(negedge clk);
        chk("e_rst_held", outs, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
